// File: rtl/calc_sched_pkg.sv
// rtl/calc_sched_pkg.sv - shared types and constants for the round-robin calc scheduler
`ifndef TS_WIDTH
`define TS_WIDTH 32
`endif
package calc_sched_pkg;
  localparam int DEF_N_CH = 8;
  localparam int DEF_TS_W = `TS_WIDTH;
  localparam int DEF_V_W  = 32;

  typedef logic [$clog2(DEF_N_CH)-1:0] ch_idx_t;

  typedef struct packed {
    logic [DEF_TS_W-1:0] T;
    logic [DEF_V_W-1:0]  V1;
    logic                isV1;
  } result_t;

  localparam logic [63:0] T_RESET = '1;
endpackage

// File: rtl/calc_sched_rr_if.sv
// rtl/calc_sched_rr_if.sv - issue/result bus between scheduler (master) and calculator (slave)
interface calc_sched_rr_if #(
  parameter int N_CH     = 8,
  parameter int TS_WIDTH = 32,
  parameter int V_WIDTH  = 32
);
  import calc_sched_pkg::*;
  localparam int CH_W = $clog2(N_CH);

  logic                iss_valid;
  logic [CH_W-1:0]     iss_ch;
  logic                iss_ready;
  logic                res_valid;
  logic [CH_W-1:0]     res_ch;
  logic [TS_WIDTH-1:0] res_T;
  logic [V_WIDTH-1:0]  res_V1;
  logic                res_isV1;

  modport master (output iss_valid, iss_ch,
                  input  iss_ready, res_valid, res_ch, res_T, res_V1, res_isV1);
  modport slave  (input  iss_valid, iss_ch,
                  output iss_ready, res_valid, res_ch, res_T, res_V1, res_isV1);
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter: rotate request past pointer, then priority-encode
module rr_arbiter
  import calc_sched_pkg::*;
#(
  parameter int N_CH = 8
) (
  input  logic [N_CH-1:0]         req,
  input  logic [$clog2(N_CH)-1:0] ptr,
  output logic [$clog2(N_CH)-1:0] grant,
  output logic                    any
);
  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0] rot;
  int              idx;
  int              off;
  int              sum;

  always_comb begin
    rot = '0;
    idx = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(ptr) + 1 + k;
      if (idx >= N_CH) idx = idx - N_CH;
      rot[k] = req[CH_W'(idx)];
    end
    any = |rot;
    off = 0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    sum = int'(ptr) + 1 + off;
    if (sum >= N_CH) sum = sum - N_CH;
    grant = CH_W'(sum);
  end
endmodule

// File: rtl/calc_sched_rr.sv
// rtl/calc_sched_rr.sv - round-robin scheduler feeding a shared pipelined calculator, per-channel result latches
// Optional urgent priority class: define CALC_SCHED_URGENT_EN.
`ifndef TS_WIDTH
`define TS_WIDTH 32
`endif
module calc_sched_rr
  import calc_sched_pkg::*;
#(
  parameter int N_CH     = 8,
  parameter int TS_WIDTH = `TS_WIDTH,
  parameter int V_WIDTH  = 32,
  parameter int MAX_OUT  = 4
) (
  input  logic                         clk,
  input  logic                         aclr,
  input  logic                         brake_clk,
  input  logic [N_CH-1:0]              calc_req,
`ifdef CALC_SCHED_URGENT_EN
  input  logic [N_CH-1:0]              urgent_req,
`endif
  calc_sched_rr_if.master              bus,
  output logic [N_CH*TS_WIDTH-1:0]     T,
  output logic [N_CH*V_WIDTH-1:0]      V1,
  output logic [N_CH-1:0]              isV1,
  output logic [N_CH-1:0]              valid,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
  output logic                         error
);
  localparam int CH_W  = $clog2(N_CH);
  localparam int OUT_W = $clog2(MAX_OUT + 1);

  logic [N_CH-1:0]     busy, inflight, req_q, valid_q, isv1_q;
  logic [TS_WIDTH-1:0] t_q  [N_CH];
  logic [V_WIDTH-1:0]  v1_q [N_CH];
  logic [CH_W-1:0]     ptr, ptr_eff, offer_ch, grant;
  logic                offer_valid, hs, res_ok, res_bad, grant_any, load;
  logic [N_CH-1:0]     offer_oh, eligible, arb_req;
  logic [OUT_W-1:0]    out_next;

  always_comb begin
    hs       = offer_valid & bus.iss_ready;
    offer_oh = '0;
    if (offer_valid) offer_oh[offer_ch] = 1'b1;
    eligible = calc_req & ~busy & ~offer_oh;
`ifdef CALC_SCHED_URGENT_EN
    arb_req = (|(eligible & urgent_req)) ? (eligible & urgent_req) : eligible;
`else
    arb_req = eligible;
`endif
    // The channel being accepted this cycle becomes the new round-robin anchor.
    ptr_eff = hs ? offer_ch : ptr;
    res_ok  = 1'b0;
    res_bad = 1'b0;
    if (bus.res_valid && !brake_clk) begin
      if (int'(bus.res_ch) < N_CH && inflight[bus.res_ch] && outstanding != '0) res_ok = 1'b1;
      else res_bad = 1'b1;
    end
    out_next = outstanding;
    if (hs && !res_ok)      out_next = outstanding + OUT_W'(1);
    else if (res_ok && !hs) out_next = outstanding - OUT_W'(1);
    load = (!offer_valid || hs) && grant_any && (int'(out_next) < MAX_OUT);
  end

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req   (arb_req),
    .ptr   (ptr_eff),
    .grant (grant),
    .any   (grant_any)
  );

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      ptr <= CH_W'(N_CH - 1);  offer_valid <= 1'b0;  offer_ch <= '0;  outstanding <= '0;
      busy <= '0;  inflight <= '0;  req_q <= '0;  valid_q <= '0;  isv1_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        t_q[i]  <= T_RESET[TS_WIDTH-1:0];
        v1_q[i] <= '0;
      end
    end else if (brake_clk) begin
      ptr <= CH_W'(N_CH - 1);  offer_valid <= 1'b0;  offer_ch <= '0;  outstanding <= '0;
      busy <= '0;  inflight <= '0;  req_q <= '0;  valid_q <= '0;  isv1_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        t_q[i]  <= T_RESET[TS_WIDTH-1:0];
        v1_q[i] <= '0;
      end
    end else begin
      req_q       <= calc_req;
      outstanding <= out_next;
      if (load) begin
        offer_valid <= 1'b1;
        offer_ch    <= grant;
      end else if (hs) begin
        offer_valid <= 1'b0;
      end
      if (hs) ptr <= offer_ch;
      for (int i = 0; i < N_CH; i++) begin
        if (hs && offer_ch == CH_W'(i)) begin
          busy[i]     <= 1'b1;
          inflight[i] <= 1'b1;
        end else begin
          if (!calc_req[i] && !inflight[i]) busy[i] <= 1'b0;
          if (res_ok && bus.res_ch == CH_W'(i)) inflight[i] <= 1'b0;
        end
        // A result landing with a fresh request edge keeps its valid flag.
        if (res_ok && bus.res_ch == CH_W'(i)) begin
          t_q[i]     <= bus.res_T;
          v1_q[i]    <= bus.res_V1;
          isv1_q[i]  <= bus.res_isV1;
          valid_q[i] <= 1'b1;
        end else if (calc_req[i] && !req_q[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr)         error <= 1'b0;
    else if (res_bad) error <= 1'b1;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_out
    assign T[g*TS_WIDTH +: TS_WIDTH] = t_q[g];
    assign V1[g*V_WIDTH +: V_WIDTH]  = v1_q[g];
  end

  assign isV1          = isv1_q;
  assign valid         = valid_q;
  assign bus.iss_valid = offer_valid;
  assign bus.iss_ch    = offer_ch;
endmodule
